alu_muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide responder beside the single-cycle `alu` in the EX stage. It accepts an M-extension operation from the pipeline via a START/BUSY/DONE handshake and computes iteratively: one bit per cycle. It returns the 32-bit result with a one-cycle DONE pulse, and the hazard unit stalls EX while BUSY is high. It uses the same SELECT codes for the M-group as `alu`, so the decoder drives both blocks identically.

---
 rtl/alu_muldiv_pkg.sv | 23 ++
 rtl/alu_muldiv_sign_adjust.sv | 13 +
 rtl/alu_muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// SELECT codes match the single-cycle alu decoder so both blocks share one decode.
package alu_muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [4:0] SEL_MUL    = 5'b11000;
  localparam logic [4:0] SEL_MULH   = 5'b11001;
  localparam logic [4:0] SEL_MULHSU = 5'b11010;
  localparam logic [4:0] SEL_MULHU  = 5'b11011;
  localparam logic [4:0] SEL_DIV    = 5'b11100;
  localparam logic [4:0] SEL_REM    = 5'b11101;
  localparam logic [4:0] SEL_DIVU   = 5'b11110;
  localparam logic [4:0] SEL_REMU   = 5'b11111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_sign_adjust.sv
// Conditional two's-complement negate, purely combinational.
// Used for operand magnitudes on entry and for the final result sign fix.
module alu_muldiv_sign_adjust #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M mul/div: one bit per cycle, DONE XLEN+1 edges after START, BUSY stalls EX.
// Optional ALU_MULDIV_EARLY_OUT_EN: div-by-zero, signed overflow and zero multiplies skip CALC.
module alu_muldiv_unit
  import alu_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      select,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   a_q, b_q, quo_q, rem_q;
  logic [2*XLEN-1:0] prod_q;

  logic            accept, skip_calc;
  logic            sgn1, sgn2, s1, s2, neg_in;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   div_shift, div_diff, mul_sum;
  logic [2*XLEN-1:0] prod_adj;
  logic [XLEN-1:0] div_sel, div_adj, fin_val, res_val;

  assign accept = (state == IDLE) && start && (select[4:3] == 2'b11);
  assign busy   = (state != IDLE);

  // Signedness per operand: MULH/DIV/REM treat both as signed, MULHSU only rs1.
  assign sgn1 = select[2] ? ~select[1] : (select[1] ^ select[0]);
  assign sgn2 = select[2] ? ~select[1] : (select[1:0] == 2'b01);
  assign s1   = sgn1 & data1[XLEN-1];
  assign s2   = sgn2 & data2[XLEN-1];
  // Quotient is never negated on divide-by-zero so it stays all ones.
  assign neg_in = ~select[2] ? (s1 ^ s2) :
                  select[0]  ? s1 : ((s1 ^ s2) & (|data2));

  alu_muldiv_sign_adjust #(.W(XLEN)) u_abs1 (.din(data1), .neg(s1), .dout(abs1));
  alu_muldiv_sign_adjust #(.W(XLEN)) u_abs2 (.din(data2), .neg(s2), .dout(abs2));

  assign div_shift = {rem_q, quo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);

  alu_muldiv_sign_adjust #(.W(2*XLEN)) u_prod_fix (.din(prod_q), .neg(neg_q), .dout(prod_adj));

  assign div_sel = op_q[0] ? rem_q : quo_q;
  alu_muldiv_sign_adjust #(.W(XLEN)) u_div_fix (.din(div_sel), .neg(neg_q), .dout(div_adj));

  assign fin_val = op_q[2]             ? div_adj :
                   (op_q[1:0] == 2'b00) ? prod_adj[XLEN-1:0] : prod_adj[2*XLEN-1:XLEN];

`ifdef ALU_MULDIV_EARLY_OUT_EN
  logic            div0, ovf, early_in, early_q;
  logic [XLEN-1:0] early_val, early_val_q;

  assign div0     = ~|data2;
  assign ovf      = (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (&data2);
  assign early_in = select[2] ? (div0 | (~select[1] & ovf)) : ((~|data1) | div0);
  // Overflow quotient equals the dividend (most negative value); overflow remainder is zero.
  assign early_val = ~select[2] ? '0 :
                     div0       ? (select[0] ? data1 : '1) :
                                  (select[0] ? '0 : data1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      early_q     <= 1'b0;
      early_val_q <= '0;
    end else if (accept) begin
      early_q     <= early_in;
      early_val_q <= early_val;
    end
  end

  assign skip_calc = early_in;
  assign res_val   = early_q ? early_val_q : fin_val;
`else
  assign skip_calc = 1'b0;
  assign res_val   = fin_val;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = skip_calc ? FIN : CALC;
      CALC:    if (cnt == CNT_W'(XLEN-1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      prod_q <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == FIN);
      case (state)
        IDLE: if (accept) begin
          cnt    <= '0;
          op_q   <= select[2:0];
          neg_q  <= neg_in;
          a_q    <= abs1;
          b_q    <= abs2;
          quo_q  <= abs1;
          rem_q  <= '0;
          prod_q <= {{XLEN{1'b0}}, abs2};
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_q[2]) begin
            // Restoring step: a borrow in the trial subtract keeps the shifted remainder.
            rem_q <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            prod_q <= {mul_sum, prod_q[XLEN-1:1]};
          end
        end
        FIN:     result <= res_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: arithmetic reference model plus per-cycle compare,
// and literal expectations per directed operation (result and START-to-DONE latency).
module tb_alu_muldiv_unit;
  import alu_muldiv_pkg::*;

  localparam int LAT_FULL = 33;
`ifdef ALU_MULDIV_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 33;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  select = SEL_MUL;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [31:0] result;
  logic        busy, done;

  int errors = 0;
  int checks = 0;
  int pcnt = 0;
  int p0 = 0;

  bit          m_pend = 1'b0;
  int          m_e = 0;
  int          m_due = 0;
  logic [31:0] m_val = '0;
  logic [31:0] m_held = '0;

  always #5 clk = ~clk;

  alu_muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .select(select),
    .data1(data1), .data2(data2), .result(result), .busy(busy), .done(done)
  );

  function automatic logic [31:0] ref_op(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    up  = '0;
    case (s)
      SEL_MUL:    up = ua * ub;
      SEL_MULH:   begin sp = sa * sb; up = sp; up = up >> 32; end
      SEL_MULHSU: begin sp = sa * $signed(ub); up = sp; up = up >> 32; end
      SEL_MULHU:  begin up = ua * ub; up = up >> 32; end
      SEL_DIV:    if (b == 0) up = 64'hFFFF_FFFF; else if (ovf) up = 64'h8000_0000;
                  else begin sp = sa / sb; up = sp; end
      SEL_REM:    if (b == 0) up = ua; else if (ovf) up = 0;
                  else begin sp = sa % sb; up = sp; end
      SEL_DIVU:   up = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
      SEL_REMU:   up = (b == 0) ? ua : ua % ub;
      default:    up = '0;
    endcase
    return up[31:0];
  endfunction

  function automatic int lat_of(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    bit sp;
    if (s[2]) sp = (b == 0) || (!s[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else      sp = (a == 0) || (b == 0);
    return sp ? LAT_SPECIAL : LAT_FULL;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) pcnt++;

  // Reference timeline: accepted START at edge E0 completes at edge E0+latency.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = 1'b0;
      m_held = '0;
    end else begin
      m_e++;
      if (m_pend && m_e == m_due) m_held = m_val;
      if (!(m_pend && m_e <= m_due) && start && select[4:3] == 2'b11) begin
        m_pend = 1'b1;
        m_due  = m_e + lat_of(select, data1, data2);
        m_val  = ref_op(select, data1, data2);
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_done", 32'(done), 32'(m_pend && m_e == m_due));
    chk("cmp_busy", 32'(busy), 32'(m_pend && m_e < m_due));
    if (!(m_pend && m_e < m_due)) chk("cmp_result", result, m_held);
  end

  task automatic launch(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    select = s;
    data1  = a;
    data2  = b;
    p0     = pcnt;
  endtask

  task automatic wait_done(input logic [31:0] exp, input int lat, input string nm);
    int g = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      g++;
    end while (!done && g < 100);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk(nm, result, exp);
    chk({nm, "_lat"}, 32'(pcnt - p0 - 1), 32'(lat));
  endtask

  task automatic run(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input string nm);
    launch(s, a, b);
    wait_done(exp, lat, nm);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Each run launches in the previous DONE cycle: back-to-back issue.
    run(SEL_MUL,    32'd5,         32'd2,         32'd10,        LAT_FULL,    "mul_5x2");
    run(SEL_DIV,    32'd10,        32'd2,         32'd5,         LAT_FULL,    "div_10_2_b2b");
    run(SEL_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, LAT_FULL,    "mulh_m2x3");
    run(SEL_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_FULL,    "mulhu_max");
    run(SEL_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_FULL,    "mulhsu_m1x2");
    run(SEL_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT_FULL,    "mul_m1xm1");
    run(SEL_REM,    32'd27,        32'd5,         32'd2,         LAT_FULL,    "rem_27_5");
    run(SEL_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_FULL,    "rem_m7_2");
    run(SEL_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_FULL,    "div_m7_2");
    run(SEL_DIVU,   32'hFFFF_FFFE, 32'd2,         32'h7FFF_FFFF, LAT_FULL,    "divu_big");
    run(SEL_REMU,   32'd27,        32'd5,         32'd2,         LAT_FULL,    "remu_27_5");
    run(SEL_DIV,    32'd10,        32'd0,         32'hFFFF_FFFF, LAT_SPECIAL, "div_by0");
    run(SEL_REM,    32'd10,        32'd0,         32'd10,        LAT_SPECIAL, "rem_by0");
    run(SEL_DIVU,   32'd10,        32'd0,         32'hFFFF_FFFF, LAT_SPECIAL, "divu_by0");
    run(SEL_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL, "div_ovf");
    run(SEL_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SPECIAL, "rem_ovf");
    run(SEL_MUL,    32'd0,         32'd123,       32'd0,         LAT_SPECIAL, "mul_zero");

    // Non-M SELECT is ignored: no BUSY, no DONE, RESULT holds.
    start = 1'b1; select = 5'b00110; data1 = 32'd9; data2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("non_m_busy", 32'(busy), 32'd0);

    // Second START at E5 while busy must be dropped.
    launch(SEL_DIV, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; select = SEL_MUL; data1 = 32'd3; data2 = 32'd3;
    wait_done(32'd14, LAT_FULL, "div_ignore_start");
    repeat (40) @(negedge clk);

    // Asynchronous abort just after E10.
    launch(SEL_DIV, 32'd1000, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run(SEL_MUL, 32'd7, 32'd6, 32'd42, LAT_FULL, "mul_after_reset");
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
